// File: rtl/bit_stuff_flex_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bit_stuff_flex_if
// Description : Bit-level handshake bundle between the bit stuffer/destuffer
//               and its neighbours (shift register / NRZI codec).
// Revision    : 1.0 - initial release
// ============================================================================
interface bit_stuff_flex_if;
   logic mode;
   logic en;
   logic bit_strobe;
   logic bit_in;
   logic bit_out;
   logic bit_valid;
   logic data_ack;
   logic stuffing;
   logic stuff_err;

   // Upstream side: drives control and the incoming bit, observes results
   modport master (
      output mode, en, bit_strobe, bit_in,
      input  bit_out, bit_valid, data_ack, stuffing, stuff_err
   );

   // Stuffer side
   modport slave (
      input  mode, en, bit_strobe, bit_in,
      output bit_out, bit_valid, data_ack, stuffing, stuff_err
   );
endinterface
`default_nettype wire

// File: rtl/bit_stuff_flex.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bit_stuff_flex
// Description : Parametrised USB bit stuffer (mode=0) / destuffer (mode=1).
//               After RUN_LEN consecutive TRIGGER_BIT values a complemented
//               bit is inserted (TX) or removed (RX).
//               Optional macro STUFF_ERR_CHK_EN compiles in the sticky
//               receive-side stuff error flag; otherwise stuff_err is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_stuff_flex #(
   parameter int   RUN_LEN     = 6,
   parameter logic TRIGGER_BIT = 1'b1
) (
   input  wire logic       clk,
   input  wire logic       rst,
   bit_stuff_flex_if.slave bus
);

   localparam int             c_RUN_W   = $clog2(RUN_LEN + 1);
   localparam logic [c_RUN_W-1:0] c_RUN_MAX = c_RUN_W'(RUN_LEN);
   localparam logic [c_RUN_W-1:0] c_RUN_ONE = c_RUN_W'(1);

   logic [c_RUN_W-1:0] r_run;
   logic               r_mode_q;
   logic               r_bit_out;
   logic               r_bit_valid;

   logic               w_stuffing;
   logic               w_trig;
   logic               w_data_ack;

   assign w_stuffing = bus.en & (r_run == c_RUN_MAX);
   assign w_trig     = (bus.bit_in == TRIGGER_BIT);

   // A bit is consumed/accepted on any live strobe that is not a stuff slot
   always_comb begin
      w_data_ack = 1'b0;
      if (bus.en && bus.bit_strobe && !w_stuffing) begin
         w_data_ack = 1'b1;
      end
   end

   // Run counter, latched mode and the registered output bit/strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run       <= '0;
         r_mode_q    <= 1'b0;
         r_bit_out   <= 1'b0;
         r_bit_valid <= 1'b0;
      end else if (!bus.en) begin
         // Between frames: mode may change, run restarts, bit_out holds
         r_run       <= '0;
         r_bit_valid <= 1'b0;
         r_mode_q    <= bus.mode;
      end else if (bus.bit_strobe) begin
         if (w_stuffing) begin
            // Stuff slot always ends the run; TX emits, RX swallows
            r_run <= '0;
            if (!r_mode_q) begin
               r_bit_out   <= ~TRIGGER_BIT;
               r_bit_valid <= 1'b1;
            end else begin
               r_bit_valid <= 1'b0;
            end
         end else begin
            r_bit_out   <= bus.bit_in;
            r_bit_valid <= 1'b1;
            r_run       <= w_trig ? (r_run + c_RUN_ONE) : '0;
         end
      end else begin
         r_bit_valid <= 1'b0;
      end
   end

`ifdef STUFF_ERR_CHK_EN
   logic r_stuff_err;

   // Sticky flag: a trigger-valued bit where a stuff bit was required (RX)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stuff_err <= 1'b0;
      end else if (!bus.en) begin
         r_stuff_err <= 1'b0;
      end else if (bus.bit_strobe && w_stuffing && r_mode_q && w_trig) begin
         r_stuff_err <= 1'b1;
      end
   end

   assign bus.stuff_err = r_stuff_err;
`else
   assign bus.stuff_err = 1'b0;
`endif

   assign bus.bit_out   = r_bit_out;
   assign bus.bit_valid = r_bit_valid;
   assign bus.data_ack  = w_data_ack;
   assign bus.stuffing  = w_stuffing;

endmodule
`default_nettype wire

// File: tb/tb_bit_stuff_flex.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bit_stuff_flex
// Description : Self-checking bench for bit_stuff_flex. Two instances
//               (RUN_LEN=6/TRIGGER=1 and RUN_LEN=3/TRIGGER=0) share one
//               stimulus stream; a history-based reference model predicts
//               every output each cycle, and directed sequences pin literal
//               line patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_stuff_flex;

`ifdef STUFF_ERR_CHK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk;
   logic rst;
   logic mode_s, en_s, stb_s, bin_s;

   int checks   = 0;
   int failures = 0;

   bit_stuff_flex_if bus_a ();
   bit_stuff_flex_if bus_b ();

   assign bus_a.mode = mode_s;  assign bus_b.mode = mode_s;
   assign bus_a.en   = en_s;    assign bus_b.en   = en_s;
   assign bus_a.bit_strobe = stb_s; assign bus_b.bit_strobe = stb_s;
   assign bus_a.bit_in = bin_s; assign bus_b.bit_in = bin_s;

   bit_stuff_flex #(.RUN_LEN(6), .TRIGGER_BIT(1'b1)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   bit_stuff_flex #(.RUN_LEN(3), .TRIGGER_BIT(1'b0)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // History of emitted (TX) / received (RX) line slots since frame start:
   // bit value plus a flag marking stuff slots. The current run is the number
   // of trailing trigger-valued data slots.
   logic [15:0] m_hb [2];
   logic [15:0] m_hs [2];
   int          m_len [2];
   logic        m_bo [2];
   logic        m_bv [2];
   logic        m_err [2];
   logic        m_mq [2];

   // Captured line output for directed literal checks
   logic [31:0] cap_v [2];
   int          cap_n [2];

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int   rl, tc;
         logic tb_t, e_stf, e_ack, stop;
         logic d_bo, d_bv, d_ack, d_stf, d_err;
         rl   = (k == 0) ? 6 : 3;
         tb_t = (k == 0) ? 1'b1 : 1'b0;
         if (k == 0) begin
            d_bo = bus_a.bit_out; d_bv = bus_a.bit_valid; d_ack = bus_a.data_ack;
            d_stf = bus_a.stuffing; d_err = bus_a.stuff_err;
         end else begin
            d_bo = bus_b.bit_out; d_bv = bus_b.bit_valid; d_ack = bus_b.data_ack;
            d_stf = bus_b.stuffing; d_err = bus_b.stuff_err;
         end
         if (d_bv === 1'b1) begin
            cap_v[k] = {cap_v[k][30:0], d_bo};
            cap_n[k]++;
         end
         if (rst) begin
            chk($sformatf("rst_bit_out[%0d]", k), {31'd0, d_bo}, 32'd0);
            chk($sformatf("rst_bit_valid[%0d]", k), {31'd0, d_bv}, 32'd0);
            chk($sformatf("rst_stuff_err[%0d]", k), {31'd0, d_err}, 32'd0);
            m_bo[k] = 1'b0; m_bv[k] = 1'b0; m_err[k] = 1'b0; m_mq[k] = 1'b0;
            m_len[k] = 0; m_hb[k] = '0; m_hs[k] = '0;
         end else begin
            tc = 0;
            stop = 1'b0;
            for (int i = 0; i < 16; i++) begin
               if (!stop && i < m_len[k] && !m_hs[k][i] && m_hb[k][i] == tb_t) tc++;
               else stop = 1'b1;
            end
            e_stf = en_s && (tc == rl);
            e_ack = en_s && stb_s && !e_stf;
            chk($sformatf("stuffing[%0d]", k), {31'd0, d_stf}, {31'd0, e_stf});
            chk($sformatf("data_ack[%0d]", k), {31'd0, d_ack}, {31'd0, e_ack});
            chk($sformatf("bit_out[%0d]", k), {31'd0, d_bo}, {31'd0, m_bo[k]});
            chk($sformatf("bit_valid[%0d]", k), {31'd0, d_bv}, {31'd0, m_bv[k]});
            chk($sformatf("stuff_err[%0d]", k), {31'd0, d_err}, {31'd0, m_err[k]});
            // advance model to the state after the coming rising edge
            if (!en_s) begin
               m_len[k] = 0; m_bv[k] = 1'b0; m_err[k] = 1'b0; m_mq[k] = mode_s;
            end else if (stb_s) begin
               m_hs[k] = {m_hs[k][14:0], e_stf};
               m_hb[k] = {m_hb[k][14:0], e_stf ? ~tb_t : bin_s};
               m_len[k] = (m_len[k] < 16) ? m_len[k] + 1 : 16;
               if (e_stf) begin
                  if (!m_mq[k]) begin m_bo[k] = ~tb_t; m_bv[k] = 1'b1; end
                  else begin
                     m_bv[k] = 1'b0;
                     if (ERR_EN && bin_s == tb_t) m_err[k] = 1'b1;
                  end
               end else begin
                  m_bo[k] = bin_s; m_bv[k] = 1'b1;
               end
            end else begin
               m_bv[k] = 1'b0;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   int          sidx;
   logic [31:0] acklow;
   logic [31:0] stfmask;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_rec();
      cap_v[0] = '0; cap_v[1] = '0; cap_n[0] = 0; cap_n[1] = 0;
      sidx = 0; acklow = '0; stfmask = '0;
   endtask

   // Present one source bit, holding it while the chosen instance stuffs
   task automatic tx_send(input logic b, input int sel);
      logic ack;
      int   guard;
      guard = 0;
      do begin
         tick();
         stb_s = 1'b1; bin_s = b;
         #2;
         sidx++;
         guard++;
         ack = (sel == 0) ? bus_a.data_ack : bus_b.data_ack;
         if (!ack) acklow[sidx] = 1'b1;
         if ((sel == 0) ? bus_a.stuffing : bus_b.stuffing) stfmask[sidx] = 1'b1;
      end while (!ack && guard < 4);
      if (!ack) chk("tx_send_stall", 32'd0, 32'd1);
   endtask

   // Present one raw line bit (receive direction)
   task automatic rx_send(input logic b);
      tick();
      stb_s = 1'b1; bin_s = b;
      #2;
      sidx++;
      if (!bus_a.data_ack) acklow[sidx] = 1'b1;
   endtask

   task automatic idle(input int n);
      tick();
      stb_s = 1'b0;
      repeat (n - 1) tick();
   endtask

   task automatic frame_off(input logic new_mode);
      tick();
      stb_s = 1'b0; en_s = 1'b0; mode_s = new_mode;
      tick();
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; mode_s = 1'b0; en_s = 1'b0; stb_s = 1'b0; bin_s = 1'b0;
      clear_rec();
      #1;
      chk("reset_bit_out_a", {31'd0, bus_a.bit_out}, 32'd0);
      chk("reset_bit_valid_a", {31'd0, bus_a.bit_valid}, 32'd0);
      chk("reset_stuffing_a", {31'd0, bus_a.stuffing}, 32'd0);
      chk("reset_data_ack_a", {31'd0, bus_a.data_ack}, 32'd0);
      chk("reset_stuff_err_a", {31'd0, bus_a.stuff_err}, 32'd0);
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // TX defaults: source 1x8 then 0
      en_s = 1'b1; clear_rec();
      for (int i = 0; i < 8; i++) tx_send(1'b1, 0);
      tx_send(1'b0, 0);
      idle(2);
      chk("tx8_line_len", cap_n[0], 32'd10);
      chk("tx8_line", cap_v[0] & 32'h3FF, 32'b1111110110);
      chk("tx8_acklow", acklow, 32'h80);
      chk("tx8_stuffing", stfmask, 32'h80);
      frame_off(1'b0);

      // TX exactly 1x6 then 0: stuff still inserted
      en_s = 1'b1; clear_rec();
      for (int i = 0; i < 6; i++) tx_send(1'b1, 0);
      tx_send(1'b0, 0);
      idle(2);
      chk("tx6_line_len", cap_n[0], 32'd8);
      chk("tx6_line", cap_v[0] & 32'hFF, 32'b11111100);
      chk("tx6_acklow", acklow, 32'h80);
      frame_off(1'b1);

      // RX line 1x6, 0, 1
      en_s = 1'b1; clear_rec();
      for (int i = 0; i < 6; i++) rx_send(1'b1);
      rx_send(1'b0);
      rx_send(1'b1);
      idle(2);
      chk("rx_len", cap_n[0], 32'd7);
      chk("rx_data", cap_v[0] & 32'h7F, 32'h7F);
      chk("rx_acklow", acklow, 32'h80);
      chk("rx_err_clean", {31'd0, bus_a.stuff_err}, 32'd0);
      frame_off(1'b1);

      // RX line 1x7: violation
      en_s = 1'b1; clear_rec();
      for (int i = 0; i < 7; i++) rx_send(1'b1);
      rx_send(1'b1);
      chk("rx_err_rise", {31'd0, bus_a.stuff_err}, {31'd0, ERR_EN});
      rx_send(1'b1);
      rx_send(1'b0);
      chk("rx_err_hold", {31'd0, bus_a.stuff_err}, {31'd0, ERR_EN});
      tick();
      stb_s = 1'b0; en_s = 1'b0;
      chk("rx_err_pre_clear", {31'd0, bus_a.stuff_err}, {31'd0, ERR_EN});
      tick();
      chk("rx_err_clear", {31'd0, bus_a.stuff_err}, 32'd0);
      frame_off(1'b0);

      // TX 1x4, en low one cycle, 1x4: no stuff
      en_s = 1'b1; clear_rec();
      for (int i = 0; i < 4; i++) tx_send(1'b1, 0);
      tick();
      stb_s = 1'b0; en_s = 1'b0;
      tick();
      en_s = 1'b1;
      for (int i = 0; i < 4; i++) tx_send(1'b1, 0);
      idle(2);
      chk("split_acklow", acklow, 32'd0);
      chk("split_len", cap_n[0], 32'd8);
      chk("split_line", cap_v[0] & 32'hFF, 32'hFF);
      frame_off(1'b0);

      // RUN_LEN=3, TRIGGER=0 instance: source 0x4, then reset mid-frame
      en_s = 1'b1; clear_rec();
      for (int i = 0; i < 4; i++) tx_send(1'b0, 1);
      tx_send(1'b0, 1);
      @(posedge clk);
      #2;
      chk("b_pre_rst_valid", {31'd0, bus_b.bit_valid}, 32'd1);
      rst = 1'b1;
      #1;
      chk("b_rst_bit_out", {31'd0, bus_b.bit_out}, 32'd0);
      chk("b_rst_bit_valid", {31'd0, bus_b.bit_valid}, 32'd0);
      chk("a_rst_bit_valid", {31'd0, bus_a.bit_valid}, 32'd0);
      stb_s = 1'b0;
      chk("b_line_len", cap_n[1], 32'd5);
      chk("b_line", cap_v[1] & 32'h1F, 32'b00010);
      tick();
      rst = 1'b0;
      tick();

      // Randomised phase
      for (int i = 0; i < 4000; i++) begin
         int bias;
         tick();
         bias   = ((i / 500) % 2 == 0) ? 75 : 25;
         rst    = ($urandom_range(0, 499) == 0);
         en_s   = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 7) == 0) mode_s = ~mode_s;
         stb_s  = ($urandom_range(0, 3) != 0);
         bin_s  = ($urandom_range(0, 99) < bias);
      end
      tick();
      rst = 1'b0; en_s = 1'b0; stb_s = 1'b0;
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bit_stuff_flex.md
# bit_stuff_flex

Parametrised bit stuffer/destuffer for the USB datapath. It sits between the shift register and the NRZI encoder on transmit, and between the NRZI decoder and the receive shift register on receive. After RUN_LEN consecutive TRIGGER_BIT values it inserts (TX) or removes (RX) one complemented bit. An optional sticky stuff-error flag reports receive-side protocol violations.

## Interface
Parameters:
- RUN_LEN, default 6: consecutive trigger bits before a stuff slot; legal range 1..15. The counter width is derived internally as $clog2(RUN_LEN+1).
- TRIGGER_BIT, default 1'b1: bit value that is counted; the stuff bit is ~TRIGGER_BIT.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- mode, input, 1: 0 = stuff (TX), 1 = destuff (RX).
- en, input, 1: frame active; low clears the run count.
- bit_strobe, input, 1: one-cycle pulse per bit time.
- bit_in, input, 1: TX = source data bit; RX = decoded line bit.
- bit_out, output, 1: registered; TX = line bit; RX = recovered data bit.
- bit_valid, output, 1: registered one-cycle pulse marking a new bit_out.
- data_ack, output, 1: combinational; TX = source bit consumed (shift enable); RX = data bit accepted.
- stuffing, output, 1: combinational; current slot is a stuff slot (run == RUN_LEN).
- stuff_err, output, 1: sticky error flag; present only with STUFF_ERR_CHK_EN, otherwise tied 0.

## Operation
- State:
  - run: run counter.
  - mode_q: registered mode.
  - bit_out, bit_valid, stuff_err (if enabled).
- mode_q loads mode on every cycle with en = 0 and is frozen while en = 1. Changing mode mid-frame has no effect until en drops.
- en = 0: run ← 0 and bit_valid ← 0; bit_out holds; data_ack = 0; stuff_err ← 0. en = 0 overrides a coincident bit_strobe.
- stuffing = en & (run == RUN_LEN).
- TX (mode_q = 0), on strobe:
  - If stuffing: bit_out ← ~TRIGGER_BIT, run ← 0, data_ack = 0. The source bit is held for the next slot.
  - Otherwise: bit_out ← bit_in and data_ack = 1. run ← run+1 if bit_in == TRIGGER_BIT, else run ← 0.
  - bit_valid ← 1 on every TX strobe.
- RX (mode_q = 1), on strobe:
  - If stuffing: the bit is discarded, bit_valid ← 0, data_ack = 0, run ← 0. If bit_in == TRIGGER_BIT, stuff_err ← 1.
  - Otherwise: bit_out ← bit_in, bit_valid ← 1, data_ack = 1, with the same run update as TX.
- run never exceeds RUN_LEN; the stuff slot always returns it to 0.
- A run ending exactly at RUN_LEN still produces a stuff slot, even if the following data bit is ~TRIGGER_BIT.
- With no strobe: run and bit_out hold, and bit_valid ← 0.

## Timing
- Reset values: bit_out = 0, bit_valid = 0, stuff_err = 0, run = 0, mode_q = 0. stuffing = 0 and data_ack = 0 follow from the reset state.
- Reset asserted mid-frame clears everything asynchronously. The first strobe after release is treated as a fresh run.
- data_ack and stuffing are valid in the same cycle as bit_strobe (zero latency).
- bit_out and bit_valid update on the clock edge that samples bit_strobe (1-cycle latency).
- stuff_err rises one cycle after the offending strobe and holds until en = 0 or rst.
- Back-to-back strobes on consecutive cycles are supported; throughput is 1 bit per cycle.

## Configuration
- STUFF_ERR_CHK_EN defined: the RX violation check and the sticky stuff_err register are compiled in.
- STUFF_ERR_CHK_EN undefined: stuff_err is driven constant 0. An RX stuff slot discards the bit regardless of its value. All other behaviour is identical.

## Test plan
- TX, defaults, source 1×8 then 0:
  - Line 1,1,1,1,1,1,0,1,1,0.
  - data_ack low only on the 7th strobe; stuffing high on that cycle.
- TX, source exactly 1×6 then 0: line 1×6, 0 (stuff), 0 (data); data_ack low on the 7th strobe.
- RX, line 1×6, 0, 1:
  - Six valid 1s, then no bit_valid for the stuffed 0, then valid 1.
  - stuff_err stays 0.
- RX with macro on, line 1×7:
  - stuff_err = 1 one cycle after the 7th strobe.
  - It holds through further strobes and clears the cycle after en = 0.
- TX, source 1×4, en low one cycle, then 1×4: no stuff bit inserted; data_ack high on all 8 strobes.
- Parameters RUN_LEN = 3, TRIGGER_BIT = 0, TX source 0×4: line 0,0,0,1,0; then assert rst mid-frame, and bit_out and bit_valid go to 0 immediately.
